// File: rtl/trng_postproc.sv
// ---------------------------------------------------------------------------
// trng_postproc
//
// Post-processing for the ring-oscillator TRNG. Raw sampled bits are
// optionally von Neumann debiased and then shifted into a key register.
// When a full key has been assembled, it is held for the consumer. A
// repetition-count health test watches every raw bit. If the source
// sticks, the block latches a failure and zeroes the key until cleared.
//
// Parameters
//   N_BITS_KEY  key width in bits (2..1024)
//   REP_CUTOFF  repetition-count threshold on raw bits (2..255)
//   VN_EN       1: von Neumann debiasing, 0: raw passthrough
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       run when high; low drops to IDLE and discards the key
//   raw_bit_i      sampled ring-oscillator bit
//   raw_valid_i    raw_bit_i is valid this cycle
//   clear_i        pulse that clears a latched health failure
//   key_o          assembled key, first emitted bit in the MSB
//   key_valid_o    key_o is complete and stable
//   key_ready_i    consumer accepts key_o
//   health_fail_o  sticky repetition-count failure flag
// ---------------------------------------------------------------------------
module trng_postproc #(
    parameter int N_BITS_KEY = 128,
    parameter int REP_CUTOFF = 32,
    parameter int VN_EN      = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  raw_bit_i,
    input  logic                  raw_valid_i,
    input  logic                  clear_i,
    output logic [N_BITS_KEY-1:0] key_o,
    output logic                  key_valid_o,
    input  logic                  key_ready_i,
    output logic                  health_fail_o
);

    localparam int                CW      = $clog2(N_BITS_KEY + 1);
    localparam logic [CW-1:0]     KEY_LEN = CW'(N_BITS_KEY);
    localparam logic [7:0]        CUTOFF  = 8'(REP_CUTOFF);
    localparam logic [7:0]        RUN_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        FAIL
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [N_BITS_KEY-1:0]   key_q;
    logic [N_BITS_KEY-1:0]   key_d;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_d;
    logic [CW-1:0]           count_inc;
    logic [7:0]              run_len_q;
    logic [7:0]              run_len_d;
    logic [7:0]              run_next;
    logic                    prev_bit_q;
    logic                    prev_bit_d;
    logic                    vn_second_q;
    logic                    vn_second_d;
    logic                    vn_first_q;
    logic                    vn_first_d;
    logic                    fail_q;
    logic                    fail_d;
    logic                    health_event;
    logic                    emit_valid;
    logic                    emit_bit;
    logic                    pairing_active;

    // Repetition-count test. A run length of zero means "no previous bit
    // seen since leaving IDLE or FAIL", so the next valid bit starts a fresh
    // run of 1 regardless of the stale prev_bit_q. The test stays armed in
    // FAIL so that a source which is still stuck keeps the failure latched.
    always_comb begin
        run_next = 8'd1;
        if ((run_len_q != 8'd0) && (raw_bit_i == prev_bit_q)) begin
            run_next = (run_len_q == RUN_MAX) ? RUN_MAX : run_len_q + 8'd1;
        end
        health_event = (state_q != IDLE) && raw_valid_i && (run_next >= CUTOFF);
    end

    // Debiasing. With VN enabled a bit is emitted only when the second bit
    // of a pair differs from the first, and the emitted value is the first
    // bit (10 -> 1, 01 -> 0). Without VN every valid raw bit is emitted.
    always_comb begin
        emit_valid = 1'b0;
        emit_bit   = raw_bit_i;
        if (VN_EN != 0) begin
            emit_valid = raw_valid_i && vn_second_q && (vn_first_q != raw_bit_i);
            emit_bit   = vn_first_q;
        end else begin
            emit_valid = raw_valid_i;
        end
    end

    // Pairs are only formed while bits are being accepted or held, so the
    // phase is always "first" on entry to COLLECT from IDLE or FAIL.
    assign pairing_active = (state_q == COLLECT) || (state_q == FULL);
    assign count_inc      = count_q + CW'(1);

    // Next-state and datapath. Ordinary FSM behaviour is resolved first; a
    // health event then overrides everything, including a simultaneous
    // handshake, key completion, enable drop or clear.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        count_d     = count_q;
        run_len_d   = run_len_q;
        prev_bit_d  = prev_bit_q;
        vn_second_d = vn_second_q;
        vn_first_d  = vn_first_q;
        fail_d      = fail_q;

        if (state_q == IDLE) begin
            run_len_d = 8'd0;
        end else if (raw_valid_i) begin
            run_len_d  = run_next;
            prev_bit_d = raw_bit_i;
        end

        if (pairing_active && raw_valid_i && (VN_EN != 0)) begin
            vn_second_d = ~vn_second_q;
            if (!vn_second_q) begin
                vn_first_d = raw_bit_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    key_d       = '0;
                    count_d     = '0;
                    vn_second_d = 1'b0;
                end else if (emit_valid) begin
                    key_d   = {key_q[N_BITS_KEY-2:0], emit_bit};
                    count_d = count_inc;
                    if (count_inc == KEY_LEN) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (!enable_i) begin
                    state_d     = IDLE;
                    key_d       = '0;
                    count_d     = '0;
                    vn_second_d = 1'b0;
                end else if (key_ready_i) begin
                    state_d = COLLECT;
                    key_d   = '0;
                    count_d = '0;
                end
            end
            FAIL: begin
                if (clear_i && !health_event) begin
                    state_d   = IDLE;
                    fail_d    = 1'b0;
                    run_len_d = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (health_event) begin
            state_d     = FAIL;
            fail_d      = 1'b1;
            key_d       = '0;
            count_d     = '0;
            vn_second_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: key, bit count, health test and VN pair phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_q       <= '0;
            count_q     <= '0;
            run_len_q   <= 8'd0;
            prev_bit_q  <= 1'b0;
            vn_second_q <= 1'b0;
            vn_first_q  <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            key_q       <= key_d;
            count_q     <= count_d;
            run_len_q   <= run_len_d;
            prev_bit_q  <= prev_bit_d;
            vn_second_q <= vn_second_d;
            vn_first_q  <= vn_first_d;
            fail_q      <= fail_d;
        end
    end

    // key_valid_o comes straight from the state register, so it never has a
    // combinational path from key_ready_i.
    assign key_o         = key_q;
    assign key_valid_o   = (state_q == FULL);
    assign health_fail_o = fail_q;

endmodule

// File: tb/tb_trng_postproc.sv
// ---------------------------------------------------------------------------
// tb_trng_postproc
//
// Drives two trng_postproc instances (VN_EN=1 and VN_EN=0, N_BITS_KEY=8,
// REP_CUTOFF=4) from the same raw bit stream. Each instance is compared
// every cycle against a behavioural reference model, and directed
// scenarios pin known keys and flags.
// ---------------------------------------------------------------------------
module tb_trng_postproc;

    localparam int N      = 8;
    localparam int CUTOFF = 4;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_FULL    = 2;
    localparam int M_HALT    = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         raw_bit;
    logic         raw_valid;
    logic         clear;
    logic         key_ready;
    logic [N-1:0] key_vn;
    logic         valid_vn;
    logic         flag_vn;
    logic [N-1:0] key_raw;
    logic         valid_raw;
    logic         flag_raw;

    int checks   = 0;
    int failures = 0;

    int           m_mode    [2];
    logic [N-1:0] m_key     [2];
    int           m_nbits   [2];
    int           m_run     [2];
    bit           m_last    [2];
    bit           m_half    [2];
    bit           m_half_ok [2];
    bit           m_flag    [2];

    always #5 clk = ~clk;

    trng_postproc #(.N_BITS_KEY(N), .REP_CUTOFF(CUTOFF), .VN_EN(1)) dut_vn (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .raw_bit_i    (raw_bit),
        .raw_valid_i  (raw_valid),
        .clear_i      (clear),
        .key_o        (key_vn),
        .key_valid_o  (valid_vn),
        .key_ready_i  (key_ready),
        .health_fail_o(flag_vn)
    );

    trng_postproc #(.N_BITS_KEY(N), .REP_CUTOFF(CUTOFF), .VN_EN(0)) dut_raw (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .raw_bit_i    (raw_bit),
        .raw_valid_i  (raw_valid),
        .clear_i      (clear),
        .key_o        (key_raw),
        .key_valid_o  (valid_raw),
        .key_ready_i  (key_ready),
        .health_fail_o(flag_raw)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m]    = M_IDLE;
            m_key[m]     = '0;
            m_nbits[m]   = 0;
            m_run[m]     = 0;
            m_last[m]    = 1'b0;
            m_half[m]    = 1'b0;
            m_half_ok[m] = 1'b0;
            m_flag[m]    = 1'b0;
        end
    endtask

    // Instance 0 debiases, instance 1 passes raw bits through.
    task automatic modelStep(input int m);
        int r;
        bit bad;
        bit e;
        bit eb;
        bit vn;
        vn = (m == 0);
        if (m_mode[m] == M_IDLE) begin
            m_run[m] = 0;
            if (enable) m_mode[m] = M_COLLECT;
            return;
        end
        r   = m_run[m];
        bad = 1'b0;
        if (raw_valid) begin
            if (r > 0 && raw_bit == m_last[m]) r = (r < 255) ? r + 1 : 255;
            else r = 1;
            m_last[m] = raw_bit;
            bad = (r >= CUTOFF);
        end
        m_run[m] = r;
        e  = 1'b0;
        eb = 1'b0;
        if (raw_valid && (m_mode[m] == M_COLLECT || m_mode[m] == M_FULL)) begin
            if (!vn) begin
                e  = 1'b1;
                eb = raw_bit;
            end else if (m_half_ok[m]) begin
                e  = (m_half[m] != raw_bit);
                eb = m_half[m];
                m_half_ok[m] = 1'b0;
            end else begin
                m_half[m]    = raw_bit;
                m_half_ok[m] = 1'b1;
            end
        end
        if (bad) begin
            m_mode[m]    = M_HALT;
            m_flag[m]    = 1'b1;
            m_key[m]     = '0;
            m_nbits[m]   = 0;
            m_half_ok[m] = 1'b0;
        end else if (m_mode[m] == M_HALT) begin
            if (clear) begin
                m_mode[m] = M_IDLE;
                m_flag[m] = 1'b0;
                m_run[m]  = 0;
            end
        end else if (!enable) begin
            m_mode[m]    = M_IDLE;
            m_key[m]     = '0;
            m_nbits[m]   = 0;
            m_half_ok[m] = 1'b0;
        end else if (m_mode[m] == M_FULL) begin
            if (key_ready) begin
                m_mode[m]  = M_COLLECT;
                m_key[m]   = '0;
                m_nbits[m] = 0;
            end
        end else if (e) begin
            m_key[m]   = (m_key[m] << 1) | N'(eb);
            m_nbits[m] = m_nbits[m] + 1;
            if (m_nbits[m] == N) m_mode[m] = M_FULL;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else begin
            modelStep(0);
            modelStep(1);
        end
    end

    // Every cycle out of reset, both instances must track the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("vn_key",    32'(key_vn),    32'(m_key[0]));
            checkOutput("vn_valid",  32'(valid_vn),  32'(m_mode[0] == M_FULL));
            checkOutput("vn_flag",   32'(flag_vn),   32'(m_flag[0]));
            checkOutput("raw_key",   32'(key_raw),   32'(m_key[1]));
            checkOutput("raw_valid", 32'(valid_raw), 32'(m_mode[1] == M_FULL));
            checkOutput("raw_flag",  32'(flag_raw),  32'(m_flag[1]));
        end
    end

    task automatic applyStimulus(input bit en, input bit b, input bit v,
                                 input bit clr, input bit rdy);
        enable    = en;
        raw_bit   = b;
        raw_valid = v;
        clear     = clr;
        key_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic feedPair(input bit b);
        applyStimulus(1'b1, b, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, ~b, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pattern;
        logic [5:0] discard_raw;
        logic [3:0] five_tail;
        logic [6:0] fill_tail;
        bit         b;
        bit         prev;

        rst       = 1'b1;
        enable    = 1'b0;
        raw_bit   = 1'b0;
        raw_valid = 1'b0;
        clear     = 1'b0;
        key_ready = 1'b0;
        modelReset();
        #2;
        checkOutput("reset_key",   32'(key_vn),   32'h0);
        checkOutput("reset_valid", 32'(valid_vn), 32'h0);
        checkOutput("reset_flag",  32'(flag_vn),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Von Neumann pairs spelling 8'hB2, then a 10-cycle stall.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pattern = 8'hB2;
        for (int i = N - 1; i >= 0; i--) feedPair(pattern[i]);
        checkOutput("vn_valid_after_last_pair", 32'(valid_vn), 32'h1);
        checkOutput("vn_key_b2", 32'(key_vn), 32'hB2);
        checkOutput("model_vn_key_b2", 32'(m_key[0]), 32'hB2);
        checkOutput("raw_key_first_8_raw", 32'(key_raw), 32'h9A);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("vn_key_held_stall", 32'(key_vn), 32'hB2);
        checkOutput("vn_valid_held_stall", 32'(valid_vn), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("vn_valid_after_handshake", 32'(valid_vn), 32'h0);

        // Pairs 00, 11, 10: only the last emits.
        discard_raw = 6'b001110;
        for (int i = 5; i >= 0; i--) applyStimulus(1'b1, discard_raw[i], 1'b1, 1'b0, 1'b0);
        checkOutput("vn_discard_key", 32'(key_vn), 32'h01);
        checkOutput("model_vn_discard_key", 32'(m_key[0]), 32'h01);

        // Four more emitted bits (five total), then drop enable.
        five_tail = 4'b0101;
        for (int i = 3; i >= 0; i--) feedPair(five_tail[i]);
        checkOutput("vn_five_bits_key", 32'(key_vn), 32'h15);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("enable_drop_key", 32'(key_vn), 32'h0);
        checkOutput("enable_drop_raw_valid", 32'(valid_raw), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feedPair(1'b1);
        checkOutput("reenable_key", 32'(key_vn), 32'h01);

        // Fill the key, then a handshake in the same cycle a bit is emitted.
        fill_tail = 7'b1010101;
        for (int i = 6; i >= 0; i--) feedPair(fill_tail[i]);
        checkOutput("vn_full_key_d5", 32'(key_vn), 32'hD5);
        checkOutput("vn_full_valid", 32'(valid_vn), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("collision_valid", 32'(valid_vn), 32'h0);
        checkOutput("collision_key", 32'(key_vn), 32'h0);
        feedPair(1'b1);
        checkOutput("collision_restart_key", 32'(key_vn), 32'h01);

        // Run of four ones trips the health test.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("run3_no_flag", 32'(flag_vn), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("run4_flag", 32'(flag_vn), 32'h1);
        checkOutput("run4_raw_flag", 32'(flag_raw), 32'h1);
        checkOutput("run4_key_zero", 32'(key_vn), 32'h0);
        checkOutput("run4_valid_zero", 32'(valid_vn), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("clear_with_new_event_flag", 32'(flag_vn), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_flag", 32'(flag_vn), 32'h0);

        // Raw passthrough spelling 8'hB2, then async reset mid-key.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = N - 1; i >= 0; i--) applyStimulus(1'b1, pattern[i], 1'b1, 1'b0, 1'b0);
        checkOutput("raw_key_b2", 32'(key_raw), 32'hB2);
        checkOutput("raw_valid_b2", 32'(valid_raw), 32'h1);
        checkOutput("model_raw_key_b2", 32'(m_key[1]), 32'hB2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("raw_partial_key", 32'(key_raw), 32'h05);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_raw_key", 32'(key_raw), 32'h0);
        checkOutput("async_reset_raw_valid", 32'(valid_raw), 32'h0);
        checkOutput("async_reset_vn_key", 32'(key_vn), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic with a bias toward alternating bits.
        prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            b = ($urandom_range(0, 2) != 0) ? ~prev : prev;
            prev = b;
            applyStimulus($urandom_range(0, 39) != 0, b, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
